// File: rtl/delay_ctrl_pkg.sv
// rtl/delay_ctrl_pkg.sv - shared state encodings and width helper for the delay line controller
// Contents: ST_IDLE/ST_FLUSH/ST_FILL/ST_RUN state constants, addr_width() derivation.
package delay_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    // Address width for a shift register of max_length taps; never below 1 bit.
    function automatic int addr_width(input int max_length);
        return (max_length > 1) ? $clog2(max_length) : 1;
    endfunction

endpackage

// File: rtl/delay_fill_counter.sv
// rtl/delay_fill_counter.sv - saturating count of samples shifted since the last flush
// Ports: clock, reset (sync, active-high), clear, inc, length in;
//        count (saturates at MAX_LENGTH), ge_length (count after this cycle's inc >= length) out.
module delay_fill_counter
    import delay_ctrl_pkg::*;
#(
    parameter  int MAX_LENGTH = 32,
    localparam int ADDR_WIDTH = addr_width(MAX_LENGTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ge_length
);

    localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(MAX_LENGTH);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    logic                at_max;
    logic [ADDR_WIDTH:0] count_next;

    assign at_max     = (count == COUNT_MAX);
    assign count_next = (inc && !at_max) ? (count + COUNT_ONE) : count;

    // Looks at the post-increment value so the FSM can act on the very
    // enable that completes the fill, in step with the data_out update.
    assign ge_length  = (count_next >= {1'b0, length});

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/delay_line_controller.sv
// rtl/delay_line_controller.sv - sequences a shift_register_parallel delay line: gating, length config, flush, valid flag
// Optional feature macro: DELAY_CTRL_HITLESS_EN (length changes in FILL/RUN without flushing).
// Ports: clock, reset (sync, active-high), run, sample_valid, cfg_length, cfg_req in;
//        cfg_ack, cfg_err, sr_reset, sr_enable, sr_length, out_valid, out_strobe, fill_count out.
module delay_line_controller
    import delay_ctrl_pkg::*;
#(
    parameter  int MAX_LENGTH = 32,
    localparam int ADDR_WIDTH = addr_width(MAX_LENGTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  sample_valid,
    input  logic [ADDR_WIDTH-1:0] cfg_length,
    input  logic                  cfg_req,
    output logic                  cfg_ack,
    output logic                  cfg_err,
    output logic                  sr_reset,
    output logic                  sr_enable,
    output logic [ADDR_WIDTH-1:0] sr_length,
    output logic                  out_valid,
    output logic                  out_strobe,
    output logic [ADDR_WIDTH:0]   fill_count
);

    localparam logic [ADDR_WIDTH-1:0] LEN_ONE = ADDR_WIDTH'(1);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  out_valid_next;
    logic [ADDR_WIDTH-1:0] sr_length_next;
    logic                  cfg_take;
    logic                  cfg_valid_take;
    logic                  fill_ge_length;

    // A held cfg_req is taken once per ack; if still high the cycle after
    // the ack it counts as a fresh request.
    assign cfg_take       = cfg_req && !cfg_ack;
    assign cfg_valid_take = cfg_take && (cfg_length != '0);

    assign sr_enable = sample_valid && run && ((state == ST_FILL) || (state == ST_RUN));
    assign sr_reset  = (state == ST_FLUSH);

    delay_fill_counter #(
        .MAX_LENGTH (MAX_LENGTH)
    ) u_fill_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (sr_reset),
        .inc        (sr_enable),
        .length     (sr_length),
        .count      (fill_count),
        .ge_length  (fill_ge_length)
    );

    always_comb begin
        state_next     = state;
        out_valid_next = out_valid;
        sr_length_next = sr_length;

        if (cfg_valid_take) begin
            sr_length_next = cfg_length;
        end

        case (state)
            ST_IDLE: begin
                // Config in IDLE only retargets the length; the later run
                // rising edge flushes anyway.
                if (run) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // A request landing here just updates the length: the line
                // is already empty, so no second flush is needed.
                out_valid_next = 1'b0;
                state_next     = ST_FILL;
            end
            ST_FILL, ST_RUN: begin
                if (cfg_valid_take) begin
`ifdef DELAY_CTRL_HITLESS_EN
                    // All taps keep shifting, so enough history may already
                    // exist for the new length.
                    if (fill_count >= {1'b0, cfg_length}) begin
                        state_next     = ST_RUN;
                        out_valid_next = 1'b1;
                    end else begin
                        state_next     = ST_FILL;
                        out_valid_next = 1'b0;
                    end
`else
                    state_next     = ST_FLUSH;
                    out_valid_next = 1'b0;
`endif
                end else if ((state == ST_FILL) && sr_enable && fill_ge_length) begin
                    state_next     = ST_RUN;
                    out_valid_next = 1'b1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                out_valid_next = 1'b0;
            end
        endcase

        // run low overrides everything, including a same-cycle config accept
        // (whose length update above still stands).
        if ((state != ST_IDLE) && !run) begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            sr_length  <= LEN_ONE;
            cfg_ack    <= 1'b0;
            cfg_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_strobe <= 1'b0;
        end else begin
            state      <= state_next;
            sr_length  <= sr_length_next;
            cfg_ack    <= cfg_take;
            cfg_err    <= cfg_take && (cfg_length == '0);
            out_valid  <= out_valid_next;
            out_strobe <= sr_enable && out_valid_next;
        end
    end

endmodule

// File: tb/tb_delay_line_controller.sv
// tb/tb_delay_line_controller.sv - directed scoreboard bench for delay_line_controller with a behavioural shift register
module tb_delay_line_controller;

    localparam int MAX_LENGTH = 32;
    localparam int AW         = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          run;
    logic          sample_valid;
    logic [AW-1:0] cfg_length;
    logic          cfg_req;
    logic          cfg_ack;
    logic          cfg_err;
    logic          sr_reset;
    logic          sr_enable;
    logic [AW-1:0] sr_length;
    logic          out_valid;
    logic          out_strobe;
    logic [AW:0]   fill_count;

    logic [7:0]    data_in;
    logic [7:0]    taps [MAX_LENGTH];
    logic [7:0]    data_out;

    int            n_cmp = 0;
    int            n_err = 0;
    int            k;
    int            exp_len;
    logic [7:0]    hist [$];
    logic [7:0]    exp_q [$];

    always #5 clock = ~clock;

    delay_line_controller #(
        .MAX_LENGTH (MAX_LENGTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .sample_valid (sample_valid),
        .cfg_length   (cfg_length),
        .cfg_req      (cfg_req),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err),
        .sr_reset     (sr_reset),
        .sr_enable    (sr_enable),
        .sr_length    (sr_length),
        .out_valid    (out_valid),
        .out_strobe   (out_strobe),
        .fill_count   (fill_count)
    );

    // Behavioural shift register driven by the controller outputs.
    always @(posedge clock) begin
        if (reset || sr_reset) begin
            for (int i = 0; i < MAX_LENGTH; i++) taps[i] <= 8'd0;
        end else if (sr_enable) begin
            taps[0] <= data_in;
            for (int i = 1; i < MAX_LENGTH; i++) taps[i] <= taps[i-1];
        end
    end
    assign data_out = taps[sr_length - 5'd1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Each out_strobe must match the oldest pending expected sample.
    always @(negedge clock) begin
        if (out_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'(out_strobe), 32'd0);
            end else begin
                chk("strobe_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic note_enable(input logic [7:0] val);
        hist.push_back(val);
        k++;
        if (k >= exp_len) exp_q.push_back(hist[k - exp_len]);
    endtask

    task automatic restart_epoch();
        k = 0;
        hist.delete();
    endtask

    task automatic send_sample(input logic [7:0] val, input logic exp_en, input int gap);
        sample_valid = 1'b1;
        data_in      = val;
        #1 chk("sr_enable", 32'(sr_enable), 32'(exp_en));
        if (exp_en) note_enable(val);
        tick();
        sample_valid = 1'b0;
        chk("out_valid", 32'(out_valid), 32'(k >= exp_len));
        chk("out_strobe", 32'(out_strobe), 32'(exp_en && (k >= exp_len)));
        chk("fill_count", 32'(fill_count), (k > MAX_LENGTH) ? MAX_LENGTH : k);
        repeat (gap - 1) tick();
    endtask

    task automatic do_cfg(input logic [AW-1:0] len, input logic exp_err, input logic [AW-1:0] len_after);
        int n;
        n = 0;
        cfg_req    = 1'b1;
        cfg_length = len;
        do begin
            tick();
            n++;
        end while ((cfg_ack !== 1'b1) && (n < 5));
        chk("cfg_ack", 32'(cfg_ack), 32'd1);
        chk("cfg_err", 32'(cfg_err), 32'(exp_err));
        chk("sr_length", 32'(sr_length), 32'(len_after));
        cfg_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        run          = 1'b0;
        sample_valid = 1'b0;
        cfg_req      = 1'b0;
        cfg_length   = '0;
        data_in      = 8'd0;
        k            = 0;
        exp_len      = 1;
        repeat (3) tick();
        chk("rst_sr_length", 32'(sr_length), 32'd1);
        chk("rst_sr_reset", 32'(sr_reset), 32'd0);
        chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_strobe", 32'(out_strobe), 32'd0);
        chk("rst_fill_count", 32'(fill_count), 32'd0);
        reset = 1'b0;

        // Length 4 configured in IDLE, then 10 samples every 3 cycles.
        do_cfg(5'd4, 1'b0, 5'd4);
        chk("idle_cfg_no_flush", 32'(sr_reset), 32'd0);
        exp_len = 4;
        restart_epoch();
        run = 1'b1;
        tick();
        chk("flush_sr_reset", 32'(sr_reset), 32'd1);
        send_sample(8'd99, 1'b0, 1);
        chk("fill_sr_reset_low", 32'(sr_reset), 32'd0);
        for (int i = 1; i <= 10; i++) send_sample(8'(i), 1'b1, 3);

        // Zero length rejected in RUN.
        do_cfg(5'd0, 1'b1, 5'd4);
        chk("reject_out_valid", 32'(out_valid), 32'd1);
        tick();
        chk("ack_one_pulse", 32'(cfg_ack), 32'd0);

        // Length 4 -> 8 at fill_count 12 with a coincident sample.
        send_sample(8'd11, 1'b1, 2);
        send_sample(8'd12, 1'b1, 2);
        cfg_req      = 1'b1;
        cfg_length   = 5'd8;
        sample_valid = 1'b1;
        data_in      = 8'd13;
        #1 chk("chg_sr_enable", 32'(sr_enable), 32'd1);
        exp_len = 8;
`ifdef DELAY_CTRL_HITLESS_EN
        note_enable(8'd13);
`endif
        tick();
        sample_valid = 1'b0;
        cfg_req      = 1'b0;
        chk("chg_cfg_ack", 32'(cfg_ack), 32'd1);
        chk("chg_sr_length", 32'(sr_length), 32'd8);
`ifdef DELAY_CTRL_HITLESS_EN
        chk("chg_no_flush", 32'(sr_reset), 32'd0);
        chk("chg_out_valid", 32'(out_valid), 32'd1);
        chk("chg_out_strobe", 32'(out_strobe), 32'd1);
`else
        chk("chg_flush", 32'(sr_reset), 32'd1);
        chk("chg_out_valid", 32'(out_valid), 32'd0);
        chk("chg_out_strobe", 32'(out_strobe), 32'd0);
        tick();
        chk("chg_fill_cleared", 32'(fill_count), 32'd0);
        restart_epoch();
`endif
        for (int i = 0; i < 8; i++) send_sample(8'(20 + i), 1'b1, 2);

        // run dropped mid-FILL at fill_count 2, then re-raised.
        run = 1'b0;
        tick();
        chk("stop_out_valid", 32'(out_valid), 32'd0);
        run = 1'b1;
        tick();
        chk("restart_flush", 32'(sr_reset), 32'd1);
        restart_epoch();
        tick();
        send_sample(8'd30, 1'b1, 2);
        send_sample(8'd31, 1'b1, 2);
        run          = 1'b0;
        sample_valid = 1'b1;
        data_in      = 8'd32;
        #1 chk("stop_gates_enable", 32'(sr_enable), 32'd0);
        tick();
        sample_valid = 1'b0;
        chk("stop_fill_out_valid", 32'(out_valid), 32'd0);
        chk("idle_no_flush", 32'(sr_reset), 32'd0);
        run = 1'b1;
        tick();
        chk("rerun_flush", 32'(sr_reset), 32'd1);
        tick();
        chk("rerun_fill_cleared", 32'(fill_count), 32'd0);
        restart_epoch();
        for (int i = 0; i < 8; i++) send_sample(8'(40 + i), 1'b1, 1);

        // reset while cfg_req held in FILL.
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        tick();
        restart_epoch();
        send_sample(8'd50, 1'b1, 1);
        cfg_req    = 1'b1;
        cfg_length = 5'd3;
        reset      = 1'b1;
        run        = 1'b0;
        tick();
        chk("mid_rst_sr_length", 32'(sr_length), 32'd1);
        chk("mid_rst_cfg_ack", 32'(cfg_ack), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_strobe", 32'(out_strobe), 32'd0);
        chk("mid_rst_fill_count", 32'(fill_count), 32'd0);
        chk("mid_rst_sr_reset", 32'(sr_reset), 32'd0);
        reset = 1'b0;
        restart_epoch();
        tick();
        chk("post_rst_ack", 32'(cfg_ack), 32'd1);
        chk("post_rst_no_flush", 32'(sr_reset), 32'd0);
        chk("post_rst_sr_length", 32'(sr_length), 32'd3);
        cfg_req = 1'b0;

        // Length 1 with a sample every cycle.
        do_cfg(5'd1, 1'b0, 5'd1);
        exp_len = 1;
        run = 1'b1;
        tick();
        tick();
        restart_epoch();
        for (int i = 1; i <= 6; i++) send_sample(8'(60 + i), 1'b1, 1);
        tick();
        chk("len1_strobe_off", 32'(out_strobe), 32'd0);
        chk("len1_out_valid", 32'(out_valid), 32'd1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
